ecs3_mac_tx: RTL and testbench

//  MAC-layer transmit serializer feeding the ECS3 PHY. Accepts parallel words over a

---
 rtl/ecs3_mac_tx_if.sv | 13 +
 rtl/ecs3_mac_tx.sv | 89 ++++++++
 tb/tb_ecs3_mac_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ecs3_mac_tx_if.sv
// ecs3_mac_tx_if: upper-layer word handshake plus PHY serial/select lines of the ECS3 transmitter.
interface ecs3_mac_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic tx_valid, tx_ready, rx_enable, sd_in, tx_select, rx_select, tx_done, busy;
  modport master (
    output tx_data, tx_valid, rx_enable,
    input  tx_ready, sd_in, tx_select, rx_select, tx_done, busy
  );
  modport slave (
    input  tx_data, tx_valid, rx_enable,
    output tx_ready, sd_in, tx_select, rx_select, tx_done, busy
  );
endinterface

// File: rtl/ecs3_mac_tx.sv
// ecs3_mac_tx: frames parallel words into START|data LSB-first|even parity|STOP on the ECS3 PHY, with a turnaround gap.
module ecs3_mac_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  ecs3_mac_tx_if.slave bus
);
  if (DATA_W < 1 || BIT_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
    $error("ecs3_mac_tx: DATA_W, BIT_CYCLES and GAP_CYCLES must all be >= 1");
  end
  localparam int cmax = BIT_CYCLES > GAP_CYCLES ? BIT_CYCLES : GAP_CYCLES;
  localparam int cw = $clog2(cmax + 1);
  localparam int bw = $clog2(DATA_W + 1);
  localparam logic [cw-1:0] bit_last = cw'(BIT_CYCLES - 1);
  localparam logic [cw-1:0] gap_last = cw'(GAP_CYCLES - 1);
  localparam logic [bw-1:0] data_last = bw'(DATA_W - 1);
  typedef enum logic [2:0] {st_idle, st_start, st_data, st_parity, st_stop, st_gap} state_t;
  state_t state, state_n;
  logic [cw-1:0] cyc, cyc_n;
  logic [bw-1:0] bit_idx, bit_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic par, par_n, last, accept, sd_n;
  always_comb begin
    last = cyc == bit_last;
    accept = bus.tx_valid & bus.tx_ready;
    state_n = state;
    cyc_n = last ? '0 : cyc + cw'(1);
    bit_n = bit_idx;
    sh_n = sh;
    par_n = par;
    case (state)
      st_idle: begin
        cyc_n = '0;
        if (accept) begin
          state_n = st_start;
          sh_n = bus.tx_data;
          par_n = ^bus.tx_data;
        end
      end
      st_start: if (last) begin
        state_n = st_data;
        bit_n = '0;
      end
      st_data: if (last) begin
        sh_n = sh >> 1;
        bit_n = bit_idx + bw'(1);
        state_n = bit_idx == data_last ? st_parity : st_data;
      end
      st_parity: state_n = last ? st_stop : st_parity;
      st_stop: state_n = last ? st_gap : st_stop;
      st_gap: begin
        cyc_n = cyc == gap_last ? '0 : cyc + cw'(1);
        state_n = cyc == gap_last ? st_idle : st_gap;
      end
      default: state_n = st_idle;
    endcase
    // Line outputs are registered, so they are derived from the state being entered.
    sd_n = (state_n == st_start) | (state_n == st_data & sh_n[0]) | (state_n == st_parity & par_n);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= st_idle;
      cyc <= '0;
      bit_idx <= '0;
      sh <= '0;
      par <= 1'b0;
      bus.sd_in <= 1'b0;
      bus.tx_select <= 1'b0;
      bus.tx_done <= 1'b0;
      bus.busy <= 1'b0;
      bus.tx_ready <= 1'b0;
    end else begin
      state <= state_n;
      cyc <= cyc_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      par <= par_n;
      bus.sd_in <= sd_n;
      bus.tx_select <= state_n inside {st_start, st_data, st_parity, st_stop};
      bus.tx_done <= state == st_stop && state_n == st_gap;
      bus.busy <= state_n != st_idle;
      bus.tx_ready <= state_n == st_idle;
    end
  end
  assign bus.rx_select = (state == st_idle) & bus.rx_enable;
endmodule

// File: tb/tb_ecs3_mac_tx.sv
// tb_ecs3_mac_tx: queue-based frame model checked every cycle on two instances (BIT_CYCLES 4 and 1), plus literal scenario checks.
module tb_ecs3_mac_tx;
  localparam int DW = 8;
  localparam int GC = 2;
  typedef struct packed {logic tsel; logic sd; logic done;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxen = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  ent_t q [2][$];
  bit fresh [2];
  logic [5:0] act [2];
  logic vld [2];
  logic [DW-1:0] dat [2];
  logic [5:0] rec [0:127];
  int ntsel, ndone, nrx, first_done, first_rdy, last1, start2;
  logic [10:0] bits, pat;
  ecs3_mac_tx_if #(.DATA_W(DW)) a_if ();
  ecs3_mac_tx_if #(.DATA_W(DW)) b_if ();
  ecs3_mac_tx #(.DATA_W(DW), .BIT_CYCLES(4), .GAP_CYCLES(GC)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  ecs3_mac_tx #(.DATA_W(DW), .BIT_CYCLES(1), .GAP_CYCLES(GC)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  always #5 clk = ~clk;
  assign a_if.rx_enable = rxen;
  assign b_if.rx_enable = rxen;
  // Bit order of act: busy, ready, tsel, sd, done, rxsel.
  assign act[0] = {a_if.busy, a_if.tx_ready, a_if.tx_select, a_if.sd_in, a_if.tx_done, a_if.rx_select};
  assign act[1] = {b_if.busy, b_if.tx_ready, b_if.tx_select, b_if.sd_in, b_if.tx_done, b_if.rx_select};
  assign vld[0] = a_if.tx_valid;
  assign vld[1] = b_if.tx_valid;
  assign dat[0] = a_if.tx_data;
  assign dat[1] = b_if.tx_data;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic void push_frame(input int k, input logic [DW-1:0] d);
    int bc = (k == 0) ? 4 : 1;
    logic v;
    for (int b = 0; b < DW + 3; b++) begin
      v = (b == 0) ? 1'b1 : (b <= DW) ? d[b-1] : (b == DW + 1) ? ^d : 1'b0;
      for (int c = 0; c < bc; c++) q[k].push_back('{tsel: 1'b1, sd: v, done: 1'b0});
    end
    for (int g = 0; g < GC; g++) q[k].push_back('{tsel: 1'b0, sd: 1'b0, done: g == 0});
  endfunction
  always @(negedge clk) begin
    string nm [6];
    ent_t e;
    logic idle, rdy;
    logic [5:0] ex;
    nm = '{"busy", "ready", "tsel", "sd", "done", "rxsel"};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        q[k].delete();
        fresh[k] = 1'b1;
        e = '0;
        idle = 1'b1;
        rdy = 1'b0;
      end else if (q[k].size() > 0) begin
        e = q[k].pop_front();
        idle = 1'b0;
        rdy = 1'b0;
      end else begin
        e = '0;
        idle = 1'b1;
        rdy = !fresh[k];
        if (rdy && vld[k]) push_frame(k, dat[k]);
        fresh[k] = 1'b0;
      end
      ex = {!idle, rdy, e.tsel, e.sd, e.done, idle & rxen};
      for (int f = 0; f < 6; f++) chk($sformatf("%s%0d", nm[f], k), act[k][5-f], ex[5-f]);
      chk($sformatf("excl%0d", k), act[k][3] & act[k][0], 0);
    end
  end
  initial begin
    a_if.tx_valid = 1'b0;
    a_if.tx_data = '0;
    b_if.tx_valid = 1'b0;
    b_if.tx_data = '0;
    repeat (3) step;
    chk("rst_ready", a_if.tx_ready, 0);
    chk("rst_busy", a_if.busy, 0);
    rst = 1'b0;
    repeat (2) step;
    chk("idle_sd", a_if.sd_in, 0);
    chk("idle_tsel", a_if.tx_select, 0);
    chk("idle_done", a_if.tx_done, 0);
    chk("idle_ready", a_if.tx_ready, 1);
    chk("idle_rxsel", a_if.rx_select, 1);
    a_if.tx_valid = 1'b1;
    a_if.tx_data = 8'hA5;
    for (int i = 1; i <= 50; i++) begin
      step;
      rec[i] = act[0];
      if (i == 1) begin
        a_if.tx_valid = 1'b0;
        a_if.tx_data = 8'h3C;
      end
    end
    ntsel = 0; ndone = 0; nrx = 0; first_done = 0; first_rdy = 0;
    for (int i = 1; i <= 50; i++) begin
      ntsel += int'(rec[i][3]);
      ndone += int'(rec[i][1]);
      if (i <= 46) nrx += int'(rec[i][0]);
      if (rec[i][1] && first_done == 0) first_done = i;
      if (rec[i][4] && first_rdy == 0) first_rdy = i;
    end
    for (int b = 0; b < 11; b++) bits[b] = rec[1+4*b][2];
    pat = 11'b00101001011;
    chk("a5_bits", bits, pat);
    chk("a5_tsel_cycles", ntsel, 44);
    chk("a5_tsel_first", rec[1][3], 1);
    chk("a5_tsel_after", rec[45][3], 0);
    chk("a5_done_cycle", first_done, 45);
    chk("a5_done_count", ndone, 1);
    chk("a5_ready_cycle", first_rdy, 47);
    chk("a5_rx_blocked", nrx, 0);
    chk("a5_rx_reopen", rec[47][0], 1);
    a_if.tx_valid = 1'b1;
    a_if.tx_data = 8'h01;
    for (int i = 1; i <= 100; i++) begin
      step;
      rec[i] = act[0];
      if (i == 1) a_if.tx_data = 8'hFF;
      if (i == 48) a_if.tx_valid = 1'b0;
    end
    last1 = 0; start2 = 0;
    for (int i = 2; i <= 100; i++) begin
      if (rec[i-1][3] && !rec[i][3] && last1 == 0) last1 = i - 1;
      if (!rec[i-1][3] && rec[i][3] && start2 == 0) start2 = i;
    end
    chk("b2b_par01", rec[37][2], 1);
    chk("b2b_parff", rec[84][2], 0);
    chk("b2b_start", start2, 48);
    chk("b2b_spacing", start2 - last1 - 1, 3);
    a_if.tx_valid = 1'b1;
    a_if.tx_data = 8'h5A;
    for (int i = 1; i <= 18; i++) begin
      step;
      rec[i] = act[0];
      if (i == 1) a_if.tx_valid = 1'b0;
    end
    chk("abort_pre_tsel", rec[18][3], 1);
    chk("abort_pre_sd", rec[18][2], 1);
    rst = 1'b1;
    #1;
    chk("abort_tsel", a_if.tx_select, 0);
    chk("abort_sd", a_if.sd_in, 0);
    chk("abort_busy", a_if.busy, 0);
    repeat (2) step;
    rst = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 4; i++) begin
      step;
      rec[i] = act[0];
      ndone += int'(rec[i][1]);
    end
    chk("abort_ready", rec[1][4], 1);
    chk("abort_no_done", ndone, 0);
    b_if.tx_valid = 1'b1;
    b_if.tx_data = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      step;
      rec[i] = act[1];
      if (i == 1) b_if.tx_valid = 1'b0;
    end
    ntsel = 0;
    for (int i = 1; i <= 16; i++) ntsel += int'(rec[i][3]);
    for (int b = 0; b < 11; b++) bits[b] = rec[1+b][2];
    chk("bc1_bits", bits, 11'b00000000001);
    chk("bc1_tsel_cycles", ntsel, 11);
    chk("bc1_done", rec[12][1], 1);
    chk("bc1_ready", rec[14][4], 1);
    repeat (3) step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
